// File: rtl/qeciphy_rx_frame_ctrl.sv
// qeciphy_rx_frame_ctrl
// Receive-side frame scheduler and link sequencer for the RX data monitor.
// It produces the FAW and CRC boundary strobes and sequences the link through
// DISABLED -> HUNT -> LOCKING -> UP, with FAULT recovery on monitor errors.
// Optional feature: define QECIPHY_RX_FRAME_CTRL_STATS_EN to build the
// saturating fault counter on err_count_o. Without it, err_count_o reads 0.

module qeciphy_rx_frame_ctrl #(
    parameter int FAW_BLOCKS  = 4,
    parameter int LOCK_FRAMES = 2,
    parameter int HOLDOFF     = 8
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        link_en_i,
    input  logic        sof_i,
    input  logic        faw_error_i,
    input  logic        crc_error_i,
    input  logic        remote_rx_rdy_i,
    output logic        monitor_en_o,
    output logic        faw_boundary_o,
    output logic        crc_boundary_o,
    output logic        link_up_o,
    output logic        tx_allowed_o,
    output logic        realign_o,
    output logic [2:0]  state_o,
    output logic [15:0] err_count_o
);

    typedef enum logic [2:0] {
        ST_DISABLED = 3'd0,
        ST_HUNT     = 3'd1,
        ST_LOCKING  = 3'd2,
        ST_UP       = 3'd3,
        ST_FAULT    = 3'd4
    } state_t;

    localparam logic [4:0] LAST_BLOCK = 5'(FAW_BLOCKS - 1);
    localparam logic [3:0] LOCK_LAST  = 4'(LOCK_FRAMES - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(HOLDOFF - 1);

    state_t     state, state_next;
    logic       at_faw, at_faw_next;
    logic [2:0] word, word_next;
    logic [4:0] block, block_next;
    logic [3:0] clean_cnt, clean_next;
    logic [7:0] hold_cnt, hold_next;
    logic       adv_at_faw;
    logic [2:0] adv_word;
    logic [4:0] adv_block;
    logic       error_seen;
    logic       frame_end;
    logic       run_next;
    logic       entering_fault;

    assign error_seen     = faw_error_i | crc_error_i;
    assign frame_end      = !at_faw && (word == 3'd6) && (block == LAST_BLOCK);
    assign run_next       = (state_next == ST_LOCKING) || (state_next == ST_UP);
    assign entering_fault = (state_next == ST_FAULT) && (state != ST_FAULT);

    assign monitor_en_o = (state == ST_LOCKING) || (state == ST_UP);
    assign link_up_o    = (state == ST_UP);
    assign tx_allowed_o = link_up_o && remote_rx_rdy_i;
    assign state_o      = state;

    // Frame position one word ahead: FAW word, then FAW_BLOCKS blocks of 7 words
    always_comb begin
        adv_at_faw = 1'b0;
        adv_word   = 3'd0;
        adv_block  = 5'd0;
        if (at_faw) begin
            adv_at_faw = 1'b0;
        end else if (word == 3'd6) begin
            if (block == LAST_BLOCK) begin
                adv_at_faw = 1'b1;
            end else begin
                adv_block = block + 5'd1;
            end
        end else begin
            adv_word  = word + 3'd1;
            adv_block = block;
        end
    end

    // Link sequencer next-state, frame position and qualification counters
    always_comb begin
        state_next  = state;
        at_faw_next = at_faw;
        word_next   = word;
        block_next  = block;
        clean_next  = clean_cnt;
        hold_next   = hold_cnt;
        case (state)
            ST_DISABLED: begin
                at_faw_next = 1'b1;
                word_next   = 3'd0;
                block_next  = 5'd0;
                clean_next  = 4'd0;
                hold_next   = 8'd0;
                state_next  = ST_HUNT;
            end
            ST_HUNT: begin
                if (sof_i) begin
                    state_next  = ST_LOCKING;
                    at_faw_next = 1'b1;
                    word_next   = 3'd0;
                    block_next  = 5'd0;
                    clean_next  = 4'd0;
                end
            end
            ST_LOCKING: begin
                at_faw_next = adv_at_faw;
                word_next   = adv_word;
                block_next  = adv_block;
                if (error_seen) begin
                    state_next = ST_FAULT;
                    hold_next  = 8'd0;
                end else if (frame_end) begin
                    if (clean_cnt == LOCK_LAST) begin
                        state_next = ST_UP;
                    end else begin
                        clean_next = clean_cnt + 4'd1;
                    end
                end
            end
            ST_UP: begin
                at_faw_next = adv_at_faw;
                word_next   = adv_word;
                block_next  = adv_block;
                if (error_seen) begin
                    state_next = ST_FAULT;
                    hold_next  = 8'd0;
                end
            end
            ST_FAULT: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_next = ST_HUNT;
                end else begin
                    hold_next = hold_cnt + 8'd1;
                end
            end
            default: begin
                state_next = ST_DISABLED;
            end
        endcase
        if (!link_en_i) begin
            state_next = ST_DISABLED;
        end
    end

    // State, position and registered strobes derived from the next position
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state          <= ST_DISABLED;
            at_faw         <= 1'b1;
            word           <= 3'd0;
            block          <= 5'd0;
            clean_cnt      <= 4'd0;
            hold_cnt       <= 8'd0;
            faw_boundary_o <= 1'b0;
            crc_boundary_o <= 1'b0;
            realign_o      <= 1'b0;
        end else begin
            state          <= state_next;
            at_faw         <= at_faw_next;
            word           <= word_next;
            block          <= block_next;
            clean_cnt      <= clean_next;
            hold_cnt       <= hold_next;
            faw_boundary_o <= run_next && at_faw_next;
            crc_boundary_o <= run_next && !at_faw_next && (word_next == 3'd0);
            realign_o      <= entering_fault;
        end
    end

`ifdef QECIPHY_RX_FRAME_CTRL_STATS_EN
    logic [15:0] err_count;

    // Saturating count of FAULT entries, kept across link disable
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_count <= 16'd0;
        end else if (entering_fault && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end

    assign err_count_o = err_count;
`else
    assign err_count_o = 16'd0;
`endif

endmodule
